hazard_fwd_unit: RTL and testbench

//  Parametrised forwarding/stall unit for the ID stage: N-stage bypass select, load-use and branch-in-ID stalls,

---
 rtl/hazard_fwd_unit_pkg.sv | 18 +
 rtl/hazard_fwd_unit_md_busy_tracker.sv | 45 ++++
 rtl/hazard_fwd_unit.sv | 111 +++++++++++
 tb/tb_hazard_fwd_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared constants for the ID-stage forwarding/stall unit.
package hazard_fwd_unit_pkg;

   // Architectural register index width
   localparam int unsigned REG_W       = 5;
   // MUL/DIV busy counter width (holds DIV latency)
   localparam int unsigned MD_CNT_W    = 6;
   // Forward select value meaning "take the regfile read"
   localparam int unsigned FWD_RF      = 0;
   // Bypass stage indices, youngest first
   localparam int unsigned STG_EXE     = 0;
   localparam int unsigned STG_MEM     = 1;
   localparam int unsigned STG_WB      = 2;
   // Default multi-cycle latencies
   localparam int unsigned MUL_CYC_DEF = 2;
   localparam int unsigned DIV_CYC_DEF = 33;

endpackage

// File: rtl/hazard_fwd_unit_md_busy_tracker.sv
// Tracks the in-flight MUL/DIV operation so HI/LO readers and new MD ops wait.
module md_busy_tracker
   import hazard_fwd_unit_pkg::*;
#(
   parameter int unsigned MUL_CYC = MUL_CYC_DEF,
   parameter int unsigned DIV_CYC = DIV_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic div,
   input  logic block,
   input  logic cancel,
   output logic md_busy
);

   logic [MD_CNT_W-1:0] cnt_q;
   logic [MD_CNT_W-1:0] cnt_d;
   logic                accept;

   // Cancel beats acceptance and decrement; only one operation in flight at a time
   always_comb begin
      cnt_d  = cnt_q;
      accept = start & ~block & ~cancel & (cnt_q == '0);
      if (cancel) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d = div ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MUL_CYC);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - MD_CNT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign md_busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_fwd_unit.sv
// ID-stage bypass select and pipeline stall generation.
module hazard_fwd_unit
   import hazard_fwd_unit_pkg::*;
#(
   parameter  int unsigned NUM_STG  = STG_WB + 1,
   parameter  int unsigned LOAD_STG = STG_MEM,
   parameter  int unsigned MUL_CYC  = MUL_CYC_DEF,
   parameter  int unsigned DIV_CYC  = DIV_CYC_DEF,
   localparam int unsigned SEL_W    = $clog2(NUM_STG + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [REG_W-1:0]           id_rs,
   input  logic [REG_W-1:0]           id_rt,
   input  logic                       id_use_rs,
   input  logic                       id_use_rt,
   input  logic                       id_br,
   input  logic                       id_rd_hilo,
   input  logic                       id_md_start,
   input  logic                       id_md_div,
   input  logic [REG_W*NUM_STG-1:0]   stg_reg,
   input  logic [NUM_STG-1:0]         stg_we,
   input  logic [NUM_STG-1:0]         stg_load,
   input  logic                       md_cancel,
   output logic [SEL_W-1:0]           fwda,
   output logic [SEL_W-1:0]           fwdb,
   output logic                       stall_id,
   output logic                       bubble_ex,
   output logic                       md_busy,
   output logic [31:0]                stall_cnt
);

   logic [NUM_STG-1:0] match_a;
   logic [NUM_STG-1:0] match_b;
   logic               lu_a, lu_b;
   logic               exe_a, exe_b;
   logic               load_use, br_hz, md_hz;
   logic [31:0]        stall_cnt_q, stall_cnt_d;

   // Per-stage destination match; $0 never forwards
   for (genvar gi = 0; gi < NUM_STG; gi++) begin : g_match
      logic [REG_W-1:0] dst;
      assign dst         = stg_reg[gi*REG_W +: REG_W];
      assign match_a[gi] = stg_we[gi] & (dst != '0) & (dst == id_rs);
      assign match_b[gi] = stg_we[gi] & (dst != '0) & (dst == id_rt);
   end

   // Youngest matching stage wins; remember whether it is a not-yet-ready load or EXE
   always_comb begin
      fwda  = SEL_W'(FWD_RF);
      fwdb  = SEL_W'(FWD_RF);
      lu_a  = 1'b0;
      lu_b  = 1'b0;
      exe_a = 1'b0;
      exe_b = 1'b0;
      for (int i = NUM_STG - 1; i >= 0; i--) begin
         if (match_a[i]) begin
            fwda  = SEL_W'(i + 1);
            lu_a  = stg_load[i] & (i < int'(LOAD_STG));
            exe_a = (i == int'(STG_EXE));
         end
         if (match_b[i]) begin
            fwdb  = SEL_W'(i + 1);
            lu_b  = stg_load[i] & (i < int'(LOAD_STG));
            exe_b = (i == int'(STG_EXE));
         end
      end
   end

   // Hazard sources; select ignores use flags but stalls honour them
   always_comb begin
      load_use  = (id_use_rs & lu_a) | (id_use_rt & lu_b);
      br_hz     = id_br & ((id_use_rs & exe_a) | (id_use_rt & exe_b));
      md_hz     = (id_rd_hilo | id_md_start) & md_busy;
      stall_id  = load_use | br_hz | md_hz;
      bubble_ex = stall_id;
   end

   md_busy_tracker #(
      .MUL_CYC (MUL_CYC),
      .DIV_CYC (DIV_CYC)
   ) u_md (
      .clk     (clk),
      .rst     (rst),
      .start   (id_md_start),
      .div     (id_md_div),
      .block   (load_use | br_hz),
      .cancel  (md_cancel),
      .md_busy (md_busy)
   );

   // Saturating stall-cycle counter next value
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_id && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Stall counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed scoreboard bench for hazard_fwd_unit (default parameters).
module tb_hazard_fwd_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs, id_rt;
   logic        id_use_rs, id_use_rt, id_br, id_rd_hilo, id_md_start, id_md_div;
   logic [14:0] stg_reg;
   logic [2:0]  stg_we, stg_load;
   logic        md_cancel;
   logic [1:0]  fwda, fwdb;
   logic        stall_id, bubble_ex, md_busy;
   logic [31:0] stall_cnt;

   typedef struct {
      string      tag;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       st;
      logic       bz;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   logic [31:0] exp_sc = 32'd0;

   always #5 clk = ~clk;

   hazard_fwd_unit dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_br       (id_br),
      .id_rd_hilo  (id_rd_hilo),
      .id_md_start (id_md_start),
      .id_md_div   (id_md_div),
      .stg_reg     (stg_reg),
      .stg_we      (stg_we),
      .stg_load    (stg_load),
      .md_cancel   (md_cancel),
      .fwda        (fwda),
      .fwdb        (fwdb),
      .stall_id    (stall_id),
      .bubble_ex   (bubble_ex),
      .md_busy     (md_busy),
      .stall_cnt   (stall_cnt)
   );

   task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, expv);
      end
   endtask

   // One clock cycle: queue expectation with the driven inputs, compare mid-cycle, advance
   task automatic cyc(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic st, input logic bz);
      exp_t e;
      e.tag = tag; e.fa = fa; e.fb = fb; e.st = st; e.bz = bz;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk(e.tag, "fwda",      32'(fwda),      32'(e.fa));
      chk(e.tag, "fwdb",      32'(fwdb),      32'(e.fb));
      chk(e.tag, "stall_id",  32'(stall_id),  32'(e.st));
      chk(e.tag, "bubble_ex", 32'(bubble_ex), 32'(e.st));
      chk(e.tag, "md_busy",   32'(md_busy),   32'(e.bz));
      chk(e.tag, "stall_cnt", stall_cnt,      exp_sc);
      if (rst) exp_sc = 32'd0;
      else if (e.st) exp_sc = exp_sc + 32'd1;
      @(posedge clk); #1;
   endtask

   task automatic idle_in();
      id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; id_br = 0;
      id_rd_hilo = 0; id_md_start = 0; id_md_div = 0;
      stg_reg = '0; stg_we = '0; stg_load = '0; md_cancel = 0;
   endtask

   initial begin
      idle_in();
      rst = 1'b1;
      stg_we = 3'b111;
      @(posedge clk); #1;

      // Reset with all stages writing $0
      cyc("rst0", 2'd0, 2'd0, 0, 0);
      cyc("rst1", 2'd0, 2'd0, 0, 0);
      cyc("rst2", 2'd0, 2'd0, 0, 0);
      rst = 1'b0;
      idle_in();
      cyc("idle", 2'd0, 2'd0, 0, 0);

      // Bypass priority
      stg_reg = {5'd9, 5'd5, 5'd5}; stg_we = 3'b111;
      id_rs = 5'd5; id_use_rs = 1; id_rt = 5'd9;
      cyc("fwd_exe", 2'd1, 2'd3, 0, 0);
      stg_we = 3'b110;
      cyc("fwd_mem", 2'd2, 2'd3, 0, 0);
      stg_reg = {5'd9, 5'd0, 5'd0}; stg_we = 3'b111;
      cyc("fwd_zero", 2'd0, 2'd3, 0, 0);
      stg_we = 3'b011;
      cyc("fwd_nowe", 2'd0, 2'd0, 0, 0);
      idle_in();

      // Load-use
      stg_reg = {5'd0, 5'd0, 5'd8}; stg_we = 3'b001; stg_load = 3'b001;
      id_rt = 5'd8;
      cyc("lu_nouse", 2'd0, 2'd1, 0, 0);
      id_use_rt = 1;
      cyc("lu_exe", 2'd0, 2'd1, 1, 0);
      stg_reg = {5'd0, 5'd8, 5'd0}; stg_we = 3'b010; stg_load = 3'b010;
      cyc("lu_mem", 2'd0, 2'd2, 0, 0);
      stg_reg = {5'd0, 5'd8, 5'd8}; stg_we = 3'b011; stg_load = 3'b010;
      cyc("lu_young_alu", 2'd0, 2'd1, 0, 0);
      idle_in();

      // Branch in ID
      stg_reg = {5'd0, 5'd0, 5'd7}; stg_we = 3'b001; id_rs = 5'd7; id_use_rs = 1; id_br = 1;
      cyc("br_exe", 2'd1, 2'd0, 1, 0);
      stg_reg = {5'd0, 5'd7, 5'd0}; stg_we = 3'b010;
      cyc("br_mem", 2'd2, 2'd0, 0, 0);
      idle_in();

      // DIV then mflo: 33 stall cycles
      id_md_start = 1; id_md_div = 1;
      cyc("div_issue", 2'd0, 2'd0, 0, 0);
      idle_in();
      id_rd_hilo = 1;
      for (int k = 0; k < 33; k++) cyc($sformatf("div_wait%0d", k), 2'd0, 2'd0, 1, 1);
      cyc("div_done", 2'd0, 2'd0, 0, 0);
      idle_in();

      // MUL back-to-back: second start stalls while cnt==1
      id_md_start = 1;
      cyc("mul_issue", 2'd0, 2'd0, 0, 0);
      id_md_start = 0;
      cyc("mul_cnt2", 2'd0, 2'd0, 0, 1);
      id_md_start = 1;
      cyc("mul_cnt1_new", 2'd0, 2'd0, 1, 1);
      cyc("mul_accept", 2'd0, 2'd0, 0, 0);
      id_md_start = 0;
      cyc("mul2_cnt2", 2'd0, 2'd0, 0, 1);
      cyc("mul2_cnt1", 2'd0, 2'd0, 0, 1);
      cyc("mul2_done", 2'd0, 2'd0, 0, 0);

      // Cancel DIV at cnt==20
      id_md_start = 1; id_md_div = 1;
      cyc("div2_issue", 2'd0, 2'd0, 0, 0);
      idle_in();
      for (int k = 0; k < 13; k++) cyc($sformatf("div2_run%0d", k), 2'd0, 2'd0, 0, 1);
      md_cancel = 1; id_rd_hilo = 1;
      cyc("div2_cancel", 2'd0, 2'd0, 1, 1);
      md_cancel = 0;
      cyc("div2_after", 2'd0, 2'd0, 0, 0);
      idle_in();

      // Cancel blocks a same-cycle start
      id_md_start = 1; md_cancel = 1;
      cyc("cancel_start", 2'd0, 2'd0, 0, 0);
      idle_in();
      cyc("cancel_noacc", 2'd0, 2'd0, 0, 0);

      // Load-use stall blocks MD acceptance
      stg_reg = {5'd0, 5'd0, 5'd3}; stg_we = 3'b001; stg_load = 3'b001;
      id_rs = 5'd3; id_use_rs = 1; id_md_start = 1;
      cyc("lu_md_block", 2'd1, 2'd0, 1, 0);
      idle_in();
      cyc("lu_md_noacc", 2'd0, 2'd0, 0, 0);

      // Reset mid-DIV
      id_md_start = 1; id_md_div = 1;
      cyc("div3_issue", 2'd0, 2'd0, 0, 0);
      rst = 1;
      cyc("div3_rst", 2'd0, 2'd0, 1, 1);
      rst = 0; id_md_start = 0; id_md_div = 0;
      cyc("div3_cleared", 2'd0, 2'd0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
